// File: rtl/lsu_pkg.sv
// Shared constants and FSM state type for the load/store unit.
package lsu_pkg;

    localparam int unsigned MEM_AW_DEFAULT = 6;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_RD,
        STORE_WR,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extract/extend and store read-modify-write merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_B: merged[8*offset +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// RV32I load/store unit in front of a word-only data memory; sub-word stores use read-modify-write.
module lsu_mem_access
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              state, state_next;
    logic                is_store_q;
    logic [2:0]          funct3_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic [31:0]         merge_q;
    logic [31:0]         rdata_q;
    logic                accept;
    logic                f3_bad, misaligned, out_of_range, err;
    logic [31:0]         load_data, merged;

    assign accept   = req_valid && (state == IDLE);
    assign mem_addr = addr_q[MEM_AW+1:2];

    always_comb begin
        if (req_is_store) f3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W});
        else              f3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (req_funct3)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W:        misaligned = (req_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        out_of_range = |req_addr[31:MEM_AW+2];
        err          = f3_bad || misaligned || out_of_range;
    end

    lsu_lane_align u_lane_align (
        .word      (mem_rdata),
        .wdata     (wdata_q),
        .offset    (addr_q[1:0]),
        .funct3    (funct3_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            merge_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                is_store_q <= req_is_store;
                funct3_q   <= req_funct3;
                addr_q     <= req_addr[MEM_AW+1:0];
                wdata_q    <= req_wdata;
                err_q      <= err;
                rdata_q    <= '0;
            end
            if (state == LOAD)     rdata_q <= load_data;
            if (state == STORE_RD) merge_q <= merged;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (err)                    state_next = RESP;
                    else if (!req_is_store)     state_next = LOAD;
                    else if (req_funct3 == F3_W) state_next = STORE_WR;
                    else                        state_next = STORE_RD;
                end
            end
            LOAD: begin
                mem_read   = 1'b1;
                state_next = RESP;
            end
            STORE_RD: begin
                mem_read   = 1'b1;
                state_next = STORE_WR;
            end
            STORE_WR: begin
                // write strobe is squashed by a same-cycle reset so an aborted store never commits
                mem_write  = !rst;
                mem_wdata  = (funct3_q == F3_W) ? wdata_q : merge_q;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // is_store_q is kept for debug visibility of the captured request
    logic unused_ok;
    assign unused_ok = is_store_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed vector table, reset/back-to-back sequences and random requests against a behavioural model.
module tb_lsu_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [5:0]  mem_addr;
    logic        mem_read, mem_write;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_mem_access #(.MEM_AW(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Specification-level model: legality, alignment, range, then byte arithmetic on ref_mem.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output int lat, output logic err,
                                  output logic [31:0] rd, output int nrd, output int nwr);
        int unsigned size, idx, sh;
        logic [31:0] w, mask;
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        err   = !legal || (a % size != 0) || (a >= 32'd256);
        rd = 0; nrd = 0; nwr = 0; lat = 1;
        if (!err) begin
            idx = a / 4;
            sh  = (a % 4) * 8;
            w   = ref_mem[idx];
            if (!st) begin
                lat = 2; nrd = 1;
                rd = w >> sh;
                if (size == 1) rd = rd & 32'hFF;
                else if (size == 2) rd = rd & 32'hFFFF;
                if (f3 == 3'd0 && rd[7])  rd = rd | 32'hFFFFFF00;
                if (f3 == 3'd1 && rd[15]) rd = rd | 32'hFFFF0000;
            end else begin
                nwr = 1;
                lat = (size == 4) ? 2 : 3;
                nrd = (size == 4) ? 0 : 1;
                mask = ((size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 1)) << sh;
                ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
            end
        end
    endfunction

    task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [31:0] rd, output int nrd, output int nwr,
                           output logic [31:0] wdat, output logic [5:0] waddr);
        logic bad;
        lat = 0; err = 1'bx; rd = 'x; nrd = 0; nwr = 0; wdat = 0; waddr = 0; bad = 0;
        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_is_store = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            if (mem_read && mem_write) bad = 1'b1;
            if (req_ready) bad = 1'b1;
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wdat = mem_wdata; waddr = mem_addr; end
            if (resp_valid) begin lat = c; err = resp_err; rd = resp_rdata; break; end
            @(negedge clk);
        end
        check("busy_flags", {31'd0, bad}, 32'd0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          nrd, nwr;
        logic [31:0] wdat;
        logic [5:0]  waddr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat, nrd, nwr, mlat, mnrd, mnwr;
        logic err, merr;
        logic [31:0] rd, mrd, wdat;
        logic [5:0] waddr;
        logic [5:0] rdy_trace, rsp_trace;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd;
        logic seen;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        mem[1] = 32'hA5A5A5A5; ref_mem[1] = 32'hA5A5A5A5;

        vecs[0]  = '{1'b0, 3'd0, 32'h13,  32'h0, 2, 1'b0, 32'hFFFFFFDE, 1, 0, 32'h0, 6'd0};
        vecs[1]  = '{1'b0, 3'd4, 32'h13,  32'h0, 2, 1'b0, 32'h000000DE, 1, 0, 32'h0, 6'd0};
        vecs[2]  = '{1'b0, 3'd1, 32'h12,  32'h0, 2, 1'b0, 32'hFFFFDEAD, 1, 0, 32'h0, 6'd0};
        vecs[3]  = '{1'b0, 3'd5, 32'h10,  32'h0, 2, 1'b0, 32'h0000BEEF, 1, 0, 32'h0, 6'd0};
        vecs[4]  = '{1'b1, 3'd0, 32'h11,  32'h12345655, 3, 1'b0, 32'h0, 1, 1, 32'hDEAD55EF, 6'd4};
        vecs[5]  = '{1'b0, 3'd2, 32'h10,  32'h0, 2, 1'b0, 32'hDEAD55EF, 1, 0, 32'h0, 6'd0};
        vecs[6]  = '{1'b1, 3'd2, 32'h08,  32'hCAFEF00D, 2, 1'b0, 32'h0, 0, 1, 32'hCAFEF00D, 6'd2};
        vecs[7]  = '{1'b0, 3'd2, 32'h08,  32'h0, 2, 1'b0, 32'hCAFEF00D, 1, 0, 32'h0, 6'd0};
        vecs[8]  = '{1'b0, 3'd2, 32'h12,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 6'd0};
        vecs[9]  = '{1'b1, 3'd1, 32'h11,  32'h5555, 1, 1'b1, 32'h0, 0, 0, 32'h0, 6'd0};
        vecs[10] = '{1'b0, 3'd0, 32'h100, 32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 6'd0};
        vecs[11] = '{1'b0, 3'd3, 32'h00,  32'h0, 1, 1'b1, 32'h0, 0, 0, 32'h0, 6'd0};

        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {31'd0, req_ready},  32'd1);
        check("rst_resp",   {31'd0, resp_valid}, 32'd0);
        check("rst_err",    {31'd0, resp_err},   32'd0);
        check("rst_rdata",  resp_rdata,          32'd0);
        check("rst_mrd",    {31'd0, mem_read},   32'd0);
        check("rst_mwr",    {31'd0, mem_write},  32'd0);
        check("rst_maddr",  {26'd0, mem_addr},   32'd0);
        check("rst_mwdata", mem_wdata,           32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, lat, err, rd, nrd, nwr, wdat, waddr);
            model(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, mlat, merr, mrd, mnrd, mnwr);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            check($sformatf("vec%0d_nrd", i), nrd, vecs[i].nrd);
            check($sformatf("vec%0d_nwr", i), nwr, vecs[i].nwr);
            if (vecs[i].nwr != 0) begin
                check($sformatf("vec%0d_wdata", i), wdat, vecs[i].wdat);
                check($sformatf("vec%0d_waddr", i), {26'd0, waddr}, {26'd0, vecs[i].waddr});
            end
        end

        // reset while the SW 0x04 write strobe is up
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h04; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwr_in_wr", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1 check("rstwr_gated", {31'd0, mem_write}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstwr_ready", {31'd0, req_ready}, 32'd1);
        seen = resp_valid;
        repeat (3) begin @(negedge clk); seen = seen | resp_valid; end
        check("rstwr_noresp", {31'd0, seen}, 32'd0);
        check("rstwr_mem1", mem[1], 32'hA5A5A5A5);

        // req_valid held high across two LB requests
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h13;
        for (int c = 0; c < 6; c++) begin
            rdy_trace[5-c] = req_ready;
            rsp_trace[5-c] = resp_valid;
            if (c == 2) check("b2b_rdata", resp_rdata, 32'hFFFFFFDE);
            if (c == 5) req_valid = 1'b0;
            else @(negedge clk);
        end
        check("b2b_ready", {26'd0, rdy_trace}, {26'd0, 6'b100100});
        check("b2b_resp",  {26'd0, rsp_trace}, {26'd0, 6'b001001});

        for (int n = 0; n < 150; n++) begin
            st = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(8, 31));
            wd = $urandom;
            run_req(st, f3, a, wd, lat, err, rd, nrd, nwr, wdat, waddr);
            model(st, f3, a, wd, mlat, merr, mrd, mnrd, mnwr);
            check($sformatf("rnd%0d_lat", n), lat, mlat);
            check($sformatf("rnd%0d_err", n), {31'd0, err}, {31'd0, merr});
            check($sformatf("rnd%0d_rdata", n), rd, mrd);
            check($sformatf("rnd%0d_nrd", n), nrd, mnrd);
            check($sformatf("rnd%0d_nwr", n), nwr, mnwr);
            @(negedge clk);
            check($sformatf("rnd%0d_mem", n), mem[a[7:2]], ref_mem[a[7:2]]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
